// File: rtl/beta_pkg.sv
// Shared definitions for the Beta core front end: PCSEL encodings, default
// PC vectors, fetch FSM states and the branch-offset helper.
package beta_pkg;

  // PCSEL encodings driven by the control unit.
  localparam logic [2:0] PC_INC   = 3'd0;
  localparam logic [2:0] PC_BR    = 3'd1;
  localparam logic [2:0] PC_JMP   = 3'd2;
  localparam logic [2:0] PC_ILLOP = 3'd3;
  localparam logic [2:0] PC_XADR  = 3'd4;

  // Default vectors; bit 31 set means supervisor mode.
  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

  // Fetch FSM states.
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_ISSUE = 1'b1
  } fetch_state_e;

  // Branch byte offset: sign-extended word literal scaled by 4.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    br_offset = {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/beta_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch stage and memory.
interface beta_fetch_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/beta_pc_next.sv
// Combinational next-PC selection for the Beta fetch stage. Bit 31 is the
// supervisor flag: sequential and branch targets keep it, a jump may only
// clear it, and the trap vectors set it.
module beta_pc_next
  import beta_pkg::*;
#(
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC
) (
  input  logic [31:0] pc,
  input  logic [2:0]  pcsel,
  input  logic [15:0] imm16,
  input  logic [31:0] jt,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        bad
);

  logic [31:0] inc_s;
  logic [31:0] br_s;
  logic        unused_bits_s;

  assign inc_s    = pc + 32'd4;
  assign br_s     = inc_s + br_offset(imm16);
  assign pc_plus4 = {pc[31], inc_s[30:0]};

  // Low address bits are forced to zero and carries into bit 31 are dropped.
  assign unused_bits_s = ^{jt[1:0], br_s[1:0], br_s[31], inc_s[31]};

  // Select next PC from the control unit's decision; unknown codes trap.
  always_comb begin
    next_pc = ILLOP_VEC;
    bad     = 1'b0;
    case (pcsel)
      PC_INC:   next_pc = {pc[31], inc_s[30:2], 2'b00};
      PC_BR:    next_pc = {pc[31], br_s[30:2], 2'b00};
      PC_JMP:   next_pc = {pc[31] & jt[31], jt[30:2], 2'b00};
      PC_ILLOP: next_pc = ILLOP_VEC;
      PC_XADR:  next_pc = XADR_VEC;
      default: begin
        next_pc = ILLOP_VEC;
        bad     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/beta_fetch.sv
// Beta instruction fetch stage: owns the PC, fetches one word per
// instruction over the imem req/ack bus and holds it until the control unit
// retires it with advance, at which point the selected next PC is loaded.
module beta_fetch
  import beta_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC
) (
  input  logic               clk,
  input  logic               reset,
  beta_fetch_if.master       imem,
  output logic [31:0]        instruction,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               advance,
  input  logic [2:0]         pcsel,
  input  logic [15:0]        imm16,
  input  logic [31:0]        jt,
  output logic               bad_pcsel
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         req_q, req_d;
  logic         bad_q, bad_d;

  logic [31:0]  next_pc_s;
  logic         bad_sel_s;

  beta_pc_next #(
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_pc_next (
    .pc       (pc_q),
    .pcsel    (pcsel),
    .imm16    (imm16),
    .jt       (jt),
    .next_pc  (next_pc_s),
    .pc_plus4 (pc_plus4),
    .bad      (bad_sel_s)
  );

  // Next-state logic: capture the word on ack, load the new PC on advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    bad_d   = bad_q;
    case (state_q)
      ST_FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = ST_ISSUE;
        end else begin
          req_d   = 1'b1;
          valid_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (advance) begin
          pc_d    = next_pc_s;
          valid_d = 1'b0;
          req_d   = 1'b1;
          bad_d   = bad_q | bad_sel_s;
          state_d = ST_FETCH;
        end else begin
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VEC;
      instr_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      req_q   <= 1'b1;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      bad_q   <= bad_d;
    end
  end

  // The fetch address is the PC register itself, so it is stable while waiting.
  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = req_q;
  assign instruction    = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign bad_pcsel      = bad_q;

endmodule
